topk_sort_ctrl: RTL and testbench

TOPK_SORT_CTRL -- requirements
Module: topk_sort_ctrl

---
 rtl/topk_sort_ctrl.sv | 124 ++++++++++++
 tb/tb_topk_sort_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/topk_sort_ctrl.sv
// Batch controller for an external top-k sorter: loads NUM_WORDS scores, runs the
// sorter for SORT_CYCLES cycles, then streams the TOP_K ranked results out.
module topk_sort_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_WORDS   = 32,
  parameter int TOP_K       = 10,
  parameter int SORT_CYCLES = 275
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic                            i_abort,
  input  logic                            i_in_valid,
  output logic                            o_in_ready,
  input  logic [DATA_WIDTH-1:0]           i_in_data,
  output logic                            o_sort_rst,
  output logic                            o_sort_en,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] o_array_bus,
  input  logic [DATA_WIDTH*TOP_K-1:0]     i_sort_vals,
  input  logic [6*TOP_K-1:0]              i_sort_ids,
  output logic                            o_out_valid,
  input  logic                            i_out_ready,
  output logic [DATA_WIDTH-1:0]           o_out_data,
  output logic [5:0]                      o_out_id,
  output logic                            o_out_last,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int ID_W   = 6;
  localparam int WR_W   = (NUM_WORDS > 1)   ? $clog2(NUM_WORDS)   : 1;
  localparam int CYC_W  = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;
  localparam int RANK_W = (TOP_K > 1)       ? $clog2(TOP_K)       : 1;

  localparam logic [WR_W-1:0]   WR_LAST   = WR_W'(NUM_WORDS - 1);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(SORT_CYCLES - 1);
  localparam logic [RANK_W-1:0] RANK_LAST = RANK_W'(TOP_K - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLR, S_SORT, S_DRAIN} state_t;

  state_t                          r_state;
  state_t                          w_next;
  logic [WR_W-1:0]                 r_wr_cnt;
  logic [CYC_W-1:0]                r_cyc_cnt;
  logic [RANK_W-1:0]               r_rank;
  logic [DATA_WIDTH*NUM_WORDS-1:0] r_array_bus;
  logic                            r_sort_rst;
  logic                            r_sort_en;
  logic                            w_in_xfer;
  logic                            w_out_xfer;

  assign w_in_xfer  = (r_state == S_LOAD)  && i_in_valid;
  assign w_out_xfer = (r_state == S_DRAIN) && i_out_ready;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = S_LOAD;
      S_LOAD:  if (i_abort) w_next = S_IDLE;
               else if (w_in_xfer && r_wr_cnt == WR_LAST) w_next = S_CLR;
      S_CLR:   w_next = i_abort ? S_IDLE : S_SORT;
      S_SORT:  if (i_abort) w_next = S_IDLE;
               else if (r_cyc_cnt == CYC_LAST) w_next = S_DRAIN;
      S_DRAIN: if (i_abort) w_next = S_IDLE;
               else if (w_out_xfer && r_rank == RANK_LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sort_rst <= 1'b1;
      r_sort_en  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_sort_rst <= (w_next == S_CLR);
      r_sort_en  <= (w_next == S_SORT);
    end
  end

  // NOTE: the batch buffer is reset because it is visible to the sorter and must never show stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt    <= '0;
      r_cyc_cnt   <= '0;
      r_rank      <= '0;
      r_array_bus <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_wr_cnt  <= '0;
          r_cyc_cnt <= '0;
          r_rank    <= '0;
        end
        S_LOAD: if (w_in_xfer && !i_abort) begin
          r_array_bus[r_wr_cnt*DATA_WIDTH +: DATA_WIDTH] <= i_in_data;
          r_wr_cnt <= (r_wr_cnt == WR_LAST) ? '0 : r_wr_cnt + 1'b1;
        end
        S_CLR:   r_cyc_cnt <= '0;
        S_SORT: begin
          r_cyc_cnt <= r_cyc_cnt + 1'b1;
          r_rank    <= '0;
        end
        S_DRAIN: if (w_out_xfer && !i_abort && r_rank != RANK_LAST) r_rank <= r_rank + 1'b1;
        default: ;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_LOAD);
  assign o_out_valid = (r_state == S_DRAIN);
  assign o_out_last  = (r_state == S_DRAIN) && (r_rank == RANK_LAST);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = w_out_xfer && !i_abort && (r_rank == RANK_LAST);
  assign o_sort_rst  = r_sort_rst;
  assign o_sort_en   = r_sort_en;
  assign o_array_bus = r_array_bus;
  assign o_out_data  = i_sort_vals[r_rank*DATA_WIDTH +: DATA_WIDTH];
  assign o_out_id    = i_sort_ids[r_rank*ID_W +: ID_W];

endmodule

// File: tb/tb_topk_sort_ctrl.sv
// Directed bench for topk_sort_ctrl with a behavioural sorter that publishes its
// ranking only after sort_en has been high for exactly SORT_CYCLES cycles.
module tb_topk_sort_ctrl;

  localparam int DW = 16;
  localparam int NW = 32;
  localparam int TK = 10;
  localparam int SC = 275;

  logic             clk = 1'b0;
  logic             rst, start, abort, in_valid, out_ready;
  logic [DW-1:0]    in_data;
  logic             in_ready, sort_rst, sort_en, out_valid, out_last, busy, done;
  logic [DW*NW-1:0] array_bus;
  logic [DW*TK-1:0] sort_vals;
  logic [6*TK-1:0]  sort_ids;
  logic [DW-1:0]    out_data;
  logic [5:0]       out_id;

  int n_cmp = 0;
  int n_err = 0;
  int m_cnt = 0;

  logic [DW-1:0]    scores  [NW];
  logic [DW-1:0]    exp_val [TK];
  logic [5:0]       exp_id  [TK];
  logic [DW*NW-1:0] exp_bus;

  topk_sort_ctrl #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .TOP_K(TK), .SORT_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_sort_rst(sort_rst), .o_sort_en(sort_en), .o_array_bus(array_bus),
    .i_sort_vals(sort_vals), .i_sort_ids(sort_ids),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_id(out_id), .o_out_last(out_last), .o_busy(busy), .o_done(done)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no completion, expected summary before 2 ms");
    $fatal(1);
  end

  // Descending order, ties resolved toward the lower word index.
  function automatic void model_topk(input logic [DW*NW-1:0] arr,
                                     output logic [DW*TK-1:0] v, output logic [6*TK-1:0] d);
    bit [NW-1:0] used = '0;
    int best;
    v = '0;
    d = '0;
    for (int r = 0; r < TK; r++) begin
      best = -1;
      for (int i = 0; i < NW; i++)
        if (!used[i] && (best < 0 || arr[i*DW +: DW] > arr[best*DW +: DW])) best = i;
      used[best]     = 1'b1;
      v[r*DW +: DW]  = arr[best*DW +: DW];
      d[r*6 +: 6]    = 6'(best);
    end
  endfunction

  always @(posedge clk) begin
    logic [DW*TK-1:0] v;
    logic [6*TK-1:0]  d;
    if (sort_rst) begin
      m_cnt     <= 0;
      sort_vals <= '0;
      sort_ids  <= '0;
    end else if (sort_en) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == SC - 1) begin
        model_topk(array_bus, v, d);
        sort_vals <= v;
        sort_ids  <= d;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic [DW*NW-1:0] exp);
    n_cmp++;
    assert (array_bus === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, array_bus, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    #1 check("idle_before_start", busy, 0);
    @(negedge clk);
    start = 1'b0;
    #1 check("load_busy", busy, 1);
    check("load_in_ready", in_ready, 1);
  endtask

  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = scores[i];
      #1;
      if (!in_ready) check("in_ready_during_load", in_ready, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  // Called in the CLR cycle; returns in the first DRAIN cycle.
  task automatic wait_drain(input bit noise);
    int cyc = 0, en_cnt = 0, rdy_cnt = 0;
    check("clr_sort_rst", sort_rst, 1);
    check("clr_sort_en", sort_en, 0);
    check("clr_in_ready", in_ready, 0);
    if (noise) begin
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
      start    = 1'b1;
    end
    while (!out_valid && cyc < 400) begin
      @(negedge clk);
      #1;
      cyc++;
      if (sort_en) en_cnt++;
      if (in_ready) rdy_cnt++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("latency_clr_to_out_valid", cyc, 276);
    check("sort_en_cycles", en_cnt, SC);
    check("in_ready_outside_load", rdy_cnt, 0);
  endtask

  task automatic drain(input bit toggle);
    int r = 0, step = 0;
    while (r < TK && step < 100) begin
      out_ready = toggle ? (step % 2 == 0) : 1'b1;
      #1;
      check("out_valid", out_valid, 1);
      check("out_data", out_data, exp_val[r]);
      check("out_id", out_id, exp_id[r]);
      check("out_last", out_last, (r == TK - 1));
      check("done", done, out_ready && (r == TK - 1));
      @(negedge clk);
      if (out_ready) r++;
      step++;
    end
    out_ready = 1'b0;
    #1;
    check("transfers", r, TK);
    check("after_drain_busy", busy, 0);
    check("after_drain_out_valid", out_valid, 0);
    check("after_drain_done", done, 0);
  endtask

  task automatic build_exp_bus();
    for (int i = 0; i < NW; i++) exp_bus[i*DW +: DW] = scores[i];
  endtask

  initial begin
    int bad;
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    #1;
    check("rst_sort_rst", sort_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_sort_en", sort_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check_bus("rst_array_bus", '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 check("post_rst_sort_rst", sort_rst, 0);

    // Partial batch discarded by reset.
    for (int i = 0; i < NW; i++) scores[i] = 16'hA000 + 16'(i);
    do_start();
    load_words(12);
    check("partial_word11", array_bus[11*DW +: DW], 16'hA00B);
    check("partial_still_loading", in_ready, 1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_sort_rst", sort_rst, 1);
    check_bus("midrst_array_bus", '0);
    @(negedge clk);
    rst = 1'b0;

    // Batch A: scores 0..31 in order, with in_valid/start noise during CLR/SORT.
    for (int i = 0; i < NW; i++) scores[i] = 16'(i);
    for (int r = 0; r < TK; r++) begin
      exp_val[r] = 16'(31 - r);
      exp_id[r]  = 6'(31 - r);
    end
    build_exp_bus();
    do_start();
    load_words(NW);
    check_bus("batchA_bus_after_load", exp_bus);
    wait_drain(1'b1);
    drain(1'b0);
    check_bus("batchA_bus_stable", exp_bus);

    // Abort in LOAD with a handshake in the same cycle: no write.
    for (int i = 0; i < 3; i++) scores[i] = 16'(100 + i);
    do_start();
    load_words(3);
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    abort    = 1'b1;
    #1 check("abort_load_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b0;
    #1;
    check("abort_load_busy", busy, 0);
    check("abort_load_word2", array_bus[2*DW +: DW], 16'd102);
    check("abort_load_word3", array_bus[3*DW +: DW], 16'd3);

    // Batch B: all 0x0005 except word 7 = 0xFFFF; abort at SORT cycle 100 first.
    for (int i = 0; i < NW; i++) scores[i] = 16'h0005;
    scores[7] = 16'hFFFF;
    exp_val[0] = 16'hFFFF;
    exp_id[0]  = 6'd7;
    for (int r = 1; r < TK; r++) begin
      exp_val[r] = 16'h0005;
      exp_id[r]  = (r <= 7) ? 6'(r - 1) : 6'(r);
    end
    build_exp_bus();
    do_start();
    load_words(NW);
    check("abortB_clr_sort_rst", sort_rst, 1);
    for (int i = 0; i < 101; i++) @(negedge clk);
    abort = 1'b1;
    #1;
    check("abort_sort_en_before", sort_en, 1);
    check("abort_done_before", done, 0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_sort_busy", busy, 0);
    check("abort_sort_en", sort_en, 0);
    check("abort_out_valid", out_valid, 0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (out_valid || done || sort_en) bad++;
    end
    check("abort_quiet_cycles", bad, 0);

    do_start();
    load_words(NW);
    check_bus("batchB_bus_after_load", exp_bus);
    wait_drain(1'b0);
    drain(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
